// File: rtl/alu_arb_if.sv
// Bus bundle between the two requesters, the shared ALU and the arbiter.
// master: requester/ALU side, slave: alu_arb.
interface alu_arb_if;
    logic       r0_valid;
    logic       r0_ready;
    logic [7:0] r0_a;
    logic [7:0] r0_b;
    logic [3:0] r0_ctr;
    logic       r1_valid;
    logic       r1_ready;
    logic [7:0] r1_a;
    logic [7:0] r1_b;
    logic [3:0] r1_ctr;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_ctr;
    logic [7:0] alu_o;
    logic       rsp0_valid;
    logic       rsp1_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;

    modport master (
        output r0_valid, r0_a, r0_b, r0_ctr,
        output r1_valid, r1_a, r1_b, r1_ctr,
        output alu_o,
        input  r0_ready, r1_ready, alu_a, alu_b, alu_ctr,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_err
    );

    modport slave (
        input  r0_valid, r0_a, r0_b, r0_ctr,
        input  r1_valid, r1_a, r1_b, r1_ctr,
        input  alu_o,
        output r0_ready, r1_ready, alu_a, alu_b, alu_ctr,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_arb.sv
// alu_arb: round-robin sharing of one registered 8-bit ALU between two
// requesters. Operands are registered into the ALU, a 3-stage tag pipe tracks
// in-flight ops and routes each result back to its issuer (fixed 3-cycle latency).
// Optional feature macro: ALU_ARB_ILLEGAL_CHK_EN (flags illegal op codes).
module alu_arb #(
    parameter int MAX_OUT = 2
) (
    input  logic      ck,
    input  logic      rst,
    alu_arb_if.slave  bus
);
    typedef struct packed {
        logic vld;
        logic id;
        logic err;
    } tag_t;

    localparam logic [2:0] MAX_OUT3 = 3'(MAX_OUT);

    tag_t [3:1] r_tag;
    logic [1:0] r_cnt0, r_cnt1;
    logic       r_last;
    logic [7:0] r_alu_a, r_alu_b;
    logic [3:0] r_alu_ctr;

    logic       w_rsp0, w_rsp1, w_rsp;
    logic [2:0] w_occ0, w_occ1;
    logic       w_el0, w_el1, w_g0, w_g1, w_gnt;
    logic [7:0] w_sel_a, w_sel_b;
    logic [3:0] w_sel_ctr, w_fwd_ctr;
    logic       w_illegal, w_err;

    // Responses come straight off stage 3; reset masks them so nothing in flight escapes.
    always_comb begin
        w_rsp0 = !rst && r_tag[3].vld && !r_tag[3].id;
        w_rsp1 = !rst && r_tag[3].vld &&  r_tag[3].id;
        w_rsp  = w_rsp0 | w_rsp1;
    end

    // Eligibility credits a slot retiring this cycle, so one requester with
    // MAX_OUT=3 can issue every cycle; tie goes to the one not granted last.
    always_comb begin
        w_occ0 = {1'b0, r_cnt0} - {2'b00, w_rsp0};
        w_occ1 = {1'b0, r_cnt1} - {2'b00, w_rsp1};
        w_el0  = bus.r0_valid && (w_occ0 < MAX_OUT3);
        w_el1  = bus.r1_valid && (w_occ1 < MAX_OUT3);
        w_g0   = 1'b0;
        w_g1   = 1'b0;
        if (!rst) begin
            if (w_el0 && w_el1) begin
                w_g0 = r_last;
                w_g1 = !r_last;
            end else begin
                w_g0 = w_el0;
                w_g1 = w_el1;
            end
        end
        w_gnt = w_g0 | w_g1;
    end

    // Operand mux and illegal-code screening (0010..0111 are illegal).
    always_comb begin
        w_sel_a   = w_g1 ? bus.r1_a   : bus.r0_a;
        w_sel_b   = w_g1 ? bus.r1_b   : bus.r0_b;
        w_sel_ctr = w_g1 ? bus.r1_ctr : bus.r0_ctr;
        w_illegal = !w_sel_ctr[3] && (w_sel_ctr[2:1] != 2'b00);
`ifdef ALU_ARB_ILLEGAL_CHK_EN
        w_err     = w_illegal;
        w_fwd_ctr = w_illegal ? 4'b1000 : w_sel_ctr;
`else
        w_err     = 1'b0;
        w_fwd_ctr = w_sel_ctr;
`endif
    end

    // ALU input register stage: loads on a grant, holds otherwise.
    always_ff @(posedge ck) begin
        if (rst) begin
            r_alu_a   <= 8'h00;
            r_alu_b   <= 8'h00;
            r_alu_ctr <= 4'b0000;
        end else if (w_gnt) begin
            r_alu_a   <= w_sel_a;
            r_alu_b   <= w_sel_b;
            r_alu_ctr <= w_fwd_ctr;
        end
    end

    // Tag pipe: a bubble enters when there is no grant.
    always_ff @(posedge ck) begin
        if (rst) begin
            r_tag <= '0;
        end else begin
            r_tag[1] <= '{vld: w_gnt, id: w_g1, err: w_err & w_gnt};
            r_tag[2] <= r_tag[1];
            r_tag[3] <= r_tag[2];
        end
    end

    // Outstanding counters and round-robin pointer.
    always_ff @(posedge ck) begin
        if (rst) begin
            r_cnt0 <= 2'd0;
            r_cnt1 <= 2'd0;
            r_last <= 1'b1;
        end else begin
            case ({w_g0, w_rsp0})
                2'b10:   r_cnt0 <= r_cnt0 + 2'd1;
                2'b01:   r_cnt0 <= r_cnt0 - 2'd1;
                default: r_cnt0 <= r_cnt0;
            endcase
            case ({w_g1, w_rsp1})
                2'b10:   r_cnt1 <= r_cnt1 + 2'd1;
                2'b01:   r_cnt1 <= r_cnt1 - 2'd1;
                default: r_cnt1 <= r_cnt1;
            endcase
            if (w_g0)
                r_last <= 1'b0;
            else if (w_g1)
                r_last <= 1'b1;
        end
    end

    assign bus.r0_ready   = w_g0;
    assign bus.r1_ready   = w_g1;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_ctr    = r_alu_ctr;
    assign bus.rsp0_valid = w_rsp0;
    assign bus.rsp1_valid = w_rsp1;
    assign bus.rsp_data   = (w_rsp && !r_tag[3].err) ? bus.alu_o : 8'h00;
    assign bus.rsp_err    = w_rsp && r_tag[3].err;
endmodule
